// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin request arbiter.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_e;

  // Length of the forced gap between transactions, in cycles.
  localparam int unsigned DONE_CYCLES = 1;

  // Index width for an n-entry vector; never narrower than 1 bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 32'd2) ? 32'd1 : $clog2(n);
  endfunction

endpackage

// File: rtl/req_rr_arbiter_if.sv
// Requester-side and grant-pipeline-side signals of the arbiter.
interface req_rr_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  localparam int unsigned IdxW = arb_pkg::clog2_min1(NUM_REQ);

  logic [NUM_REQ-1:0] req_i;
  logic [NUM_REQ-1:0] gnt_o;
  logic               req_o;
  logic               gnt_i;
  logic [IdxW-1:0]    owner_o;
  logic               timeout_o;
  logic               spurious_o;

  // Arbiter side.
  modport slave (
    input  req_i,
    input  gnt_i,
    output gnt_o,
    output req_o,
    output owner_o,
    output timeout_o,
    output spurious_o
  );

  // Requesters plus grant pipeline side.
  modport master (
    output req_i,
    output gnt_i,
    input  gnt_o,
    input  req_o,
    input  owner_o,
    input  timeout_o,
    input  spurious_o
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin pick: rotate so the entry after last_winner sits at
// bit 0, take the lowest set bit, then rotate the index back.
module rr_pick import arb_pkg::*; #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IdxW = clog2_min1(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IdxW-1:0]    last_winner,
  output logic               found,
  output logic [IdxW-1:0]    idx
);

  logic [NUM_REQ-1:0] rot;
  logic [IdxW-1:0]    src;
  int unsigned        offs;

  // Rotate, priority-encode from bit 0, un-rotate.
  always_comb begin
    rot  = '0;
    src  = '0;
    offs = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      src    = IdxW'((i + 32'(last_winner) + 32'd1) % NUM_REQ);
      rot[i] = req[src];
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) offs = unsigned'(i);
    end
    found = |req;
    idx   = IdxW'((offs + 32'(last_winner) + 32'd1) % NUM_REQ);
  end

endmodule

// File: rtl/req_rr_arbiter.sv
// Round-robin arbiter in front of a single req/gnt grant pipeline. Issues one
// request at a time, waits for gnt_i (bounded by GNT_TIMEOUT), then pulses the
// grant back to the winning requester. All outputs are registered.
module req_rr_arbiter import arb_pkg::*; #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned GNT_TIMEOUT = 8
) (
  input logic            clk,
  input logic            rst_n,
  req_rr_arbiter_if.slave bus
);

  localparam int unsigned IdxW = clog2_min1(NUM_REQ);
  localparam int unsigned CntW = $clog2(GNT_TIMEOUT + 1);

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [IdxW-1:0]    last_q, last_d;
  logic [IdxW-1:0]    owner_q, owner_d;
  logic               req_q, req_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               timeout_q, timeout_d;
  logic               spurious_q, spurious_d;

  logic               pick_found;
  logic [IdxW-1:0]    pick_idx;

  rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_pick (
    .req        (bus.req_i),
    .last_winner(last_q),
    .found      (pick_found),
    .idx        (pick_idx)
  );

  // Next-state and registered-output values; pulses default low every cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    owner_d    = owner_q;
    req_d      = req_q;
    gnt_d      = '0;
    timeout_d  = 1'b0;
    spurious_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        spurious_d = bus.gnt_i;
        if (pick_found) begin
          owner_d = pick_idx;
          req_d   = 1'b1;
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (bus.gnt_i) begin
          gnt_d[owner_q] = 1'b1;
          req_d          = 1'b0;
          last_d         = owner_q;
          state_d        = DONE;
        end else if (cnt_q == CntW'(GNT_TIMEOUT)) begin
          // Advance the pointer anyway so a dead requester cannot starve others.
          timeout_d = 1'b1;
          req_d     = 1'b0;
          last_d    = owner_q;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        // Forced low cycle on req_o so the pipeline sees a falling edge.
        spurious_d = bus.gnt_i;
        req_d      = 1'b0;
        state_d    = IDLE;
      end
      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      last_q     <= IdxW'(NUM_REQ - 1);
      owner_q    <= '0;
      req_q      <= 1'b0;
      gnt_q      <= '0;
      timeout_q  <= 1'b0;
      spurious_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      owner_q    <= owner_d;
      req_q      <= req_d;
      gnt_q      <= gnt_d;
      timeout_q  <= timeout_d;
      spurious_q <= spurious_d;
    end
  end

  assign bus.req_o      = req_q;
  assign bus.gnt_o      = gnt_q;
  assign bus.owner_o    = owner_q;
  assign bus.timeout_o  = timeout_q;
  assign bus.spurious_o = spurious_q;

endmodule
